i2s_master: RTL and testbench
=============================

# i2s_master

Mono I2S transmitter for the SID audio path: takes a signed 16-bit sample and drives a 4-wire I2S bus (master clock, bit clock, word select, data) to an external DAC. It sits between the resampling filter and the PM3 pins, and runs entirely on the 12 MHz system clock. The same sample is sent on both left and right channels of each frame.

## Interface
- No parameters. Frame geometry is fixed: 256 CLK per frame, 32-bit slots, 16-bit samples.
- CLK  in  1  system clock, 12 MHz; every register in the block uses this clock.
- RST  in  1  synchronous reset, active-high.
- SMP  in  16  signed two's-complement audio sample; may change at any time.
- SCK  out  1  DAC master clock, CLK/2 (6 MHz, 128·fs).
- BCK  out  1  bit clock, CLK/4 (3 MHz, 64·fs).
- DIN  out  1  serial data, MSB first.
- LCK  out  1  word select / LRCLK, CLK/256 (46.875 kHz); 0 = left, 1 = right.

## Operation
- Free-running 8-bit frame counter `c` increments by 1 every CLK and wraps from 255 to 0.
- SCK = c[0] (subject to the macro below), BCK = c[1], LCK = c[7]. All are register-derived, with no combinational path from SMP.
- Slot index s = c[6:2] gives 32 BCK periods per channel half-frame.
- Sample latch:
  - SMP is captured into `smp_q` on the cycle where c == 255.
  - Both channels of the following frame carry `smp_q`.
  - Changes to SMP at any other time have no effect until the next capture.
- Data register updates:
  - The DIN register updates only on cycles where c[1:0] == 3. The new value therefore appears when c[1:0] == 0, coinciding with the BCK falling edge.
  - The DAC samples on the BCK rising edge, at c[1:0] == 2.
- Bit mapping, standard I2S with a one-BCK delay after each LCK edge:
  - Slot 0 drives 0.
  - Slots 1..16 drive smp_q[16-s], so slot 1 is the MSB.
  - Slots 17..31 drive 0, i.e. zero-padding after the LSB.
  - The mapping is identical for LCK = 0 and LCK = 1.
- The sample is transmitted unmodified, with no scaling or saturation.

## Timing
- Reset (RST = 1 on a CLK edge):
  - Clears c, smp_q and DIN to 0, so SCK = BCK = LCK = DIN = 0 on the next cycle.
  - Counting resumes from c = 0 on the first cycle with RST low.
- Reset asserted mid-frame aborts the frame immediately. There is no partial-word completion, and the first frame after reset transmits 0 on both channels.
- Periods:
  - SCK: 2 CLK, 50 % duty.
  - BCK: 4 CLK, low for c[1:0] ∈ {0,1} and high for {2,3}.
  - LCK: 256 CLK, toggling when c[6:0] wraps to 0.
- Latency: SMP captured at c = 255 has its MSB on DIN from c = 4 through c = 7 of the next frame, i.e. 5 CLK after capture. Its LSB is at c = 64..67 (left) and c = 192..195 (right).
- DIN is stable for a full BCK period around every rising BCK edge.

## Configuration
- Macro: I2S_MASTER_SCK_EN.
- Defined: SCK = c[0], as above.
- Undefined: SCK is driven constant 0, for DACs running from an internal PLL. All other outputs are unchanged.

## Structure
- Package i2s_master_pkg holds:
  - FRAME_LEN = 256
  - SLOT_BITS = 32
  - SAMPLE_W = 16
  - the slot of the MSB, MSB_SLOT = 1
- No sub-module. Counter, sample latch and bit selector all live in i2s_master.

## Test plan
- Reset values: hold RST for 3 cycles → SCK = BCK = LCK = DIN = 0. Release → SCK rises after 1 CLK, BCK after 2, LCK after 128.
- Clock ratios: run 1024 CLK → exactly 512 SCK, 256 BCK and 4 LCK periods. Every LCK edge coincides with a BCK falling edge.
- Data format: SMP = 16'h8001 held → per half-frame, sampling DIN at BCK rising edges gives the pattern 0,1,0×14,1,0×15 on both LCK = 0 and LCK = 1.
- Latch timing: SMP = 16'h1234, switched to 16'hFFFF at c = 100 → the current frame's right channel is still 16'h1234, and the next frame carries 16'hFFFF.
- Mid-frame reset: send 16'h7FFF, assert RST at c = 40 for one cycle → all outputs 0 next cycle, and the subsequent frame sends 16'h0000.
- Macro off: build without I2S_MASTER_SCK_EN, run 512 CLK → SCK constantly 0, and BCK/LCK/DIN identical to the macro-on run.

Source files
------------

// File: rtl/i2s_master_pkg.sv
// ---------------------------------------------------------------------------
// i2s_master_pkg
//   Shared constants for the mono I2S transmitter: frame geometry, sample
//   width and the slot in which the sample MSB is placed.
//   Derived widths are provided so the RTL never hard-codes bit positions.
// ---------------------------------------------------------------------------
package i2s_master_pkg;

  localparam int FRAME_LEN = 256;  // CLK cycles per stereo frame
  localparam int SLOT_BITS = 32;   // BCK periods per channel half-frame
  localparam int SAMPLE_W  = 16;   // audio sample width
  localparam int MSB_SLOT  = 1;    // one-BCK delay after each LCK edge

  localparam int CNT_W  = $clog2(FRAME_LEN);  // frame counter width (8)
  localparam int SLOT_W = $clog2(SLOT_BITS);  // slot index width (5)
  localparam int IDX_W  = $clog2(SAMPLE_W);   // sample bit index width (4)

endpackage : i2s_master_pkg

// File: rtl/i2s_master.sv
// ---------------------------------------------------------------------------
// i2s_master
//   Mono I2S transmitter. A free-running frame counter generates the bus
//   clocks; the sample is latched once per frame and shifted out MSB first,
//   identically on the left and right channels, one BCK after each LCK edge.
//
// Ports
//   CLK  in   1   system clock (12 MHz)
//   RST  in   1   synchronous reset, active-high
//   SMP  in  16   signed sample, captured once per frame at counter 255
//   SCK  out  1   DAC master clock, CLK/2 (or constant 0, see below)
//   BCK  out  1   bit clock, CLK/4
//   DIN  out  1   serial data, changes on the BCK falling edge
//   LCK  out  1   word select, CLK/256; 0 = left, 1 = right
//
// Configuration
//   I2S_MASTER_SCK_EN  defined   : SCK toggles at CLK/2.
//                      undefined : SCK tied to 0 (DAC with internal PLL).
// ---------------------------------------------------------------------------
module i2s_master
  import i2s_master_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [SAMPLE_W-1:0] SMP,
  output logic                SCK,
  output logic                BCK,
  output logic                DIN,
  output logic                LCK
);

  logic [CNT_W-1:0]    c_q,   c_d;
  logic [SAMPLE_W-1:0] smp_q, smp_d;
  logic                din_q, din_d;

  logic [SLOT_W-1:0]   slot_nxt;
  logic [IDX_W-1:0]    bit_idx;

  // Next-state logic. DIN is loaded one CLK before the BCK falling edge, so
  // the bit chosen belongs to the slot the counter is about to enter.
  always_comb begin
    c_d      = c_q + CNT_W'(1);
    smp_d    = smp_q;
    din_d    = din_q;
    slot_nxt = c_d[CNT_W-2:2];
    // Slot MSB_SLOT carries bit SAMPLE_W-1, each later slot one bit lower.
    bit_idx  = IDX_W'(MSB_SLOT + SAMPLE_W - 1 - int'(slot_nxt));

    if (c_q == CNT_W'(FRAME_LEN - 1)) begin
      smp_d = SMP;
    end

    if (c_q[1:0] == 2'b11) begin
      if ((slot_nxt >= SLOT_W'(MSB_SLOT)) &&
          (slot_nxt <  SLOT_W'(MSB_SLOT + SAMPLE_W))) begin
        din_d = smp_q[bit_idx];
      end else begin
        din_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before this edge, regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // The sample latch is cleared too, so the frame after reset sends 0.
      c_q   <= '0;
      smp_q <= '0;
      din_q <= 1'b0;
    end else begin
      c_q   <= c_d;
      smp_q <= smp_d;
      din_q <= din_d;
    end
  end

  // All outputs come straight from registers: no path from SMP to a pin.
`ifdef I2S_MASTER_SCK_EN
  assign SCK = c_q[0];
`else
  assign SCK = 1'b0;
`endif
  assign BCK = c_q[1];
  assign LCK = c_q[CNT_W-1];
  assign DIN = din_q;

endmodule : i2s_master

// File: tb/tb_i2s_master.sv
// ---------------------------------------------------------------------------
// tb_i2s_master
//   Self-checking bench for i2s_master. The reference model tracks the frame
//   position and the sample each frame carries, and derives the expected bus
//   levels arithmetically. A small I2S receiver decodes the DUT's own BCK/LCK
//   edges into 32-bit half-frame words for protocol-level checks.
//   Follows I2S_MASTER_SCK_EN the same way as the RTL.
// ---------------------------------------------------------------------------
module tb_i2s_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] smp = 16'h0000;
  logic        sck, bck, din, lck;

  i2s_master dut (
    .CLK (clk),
    .RST (rst),
    .SMP (smp),
    .SCK (sck),
    .BCK (bck),
    .DIN (din),
    .LCK (lck)
  );

  always #5 clk = ~clk;

`ifdef I2S_MASTER_SCK_EN
  localparam bit SCK_ON = 1'b1;
`else
  localparam bit SCK_ON = 1'b0;
`endif

  localparam logic [31:0] SENTINEL = 32'hDEAD_BEEF;

  int checks   = 0;
  int failures = 0;

  // Reference model: position within the frame and the word of this frame.
  int          pos  = 0;
  logic [15:0] word = 16'h0000;

  // Receiver / edge-counting state.
  logic        prev_sck = 1'b0, prev_bck = 1'b0, prev_lck = 1'b0;
  int          bit_cnt  = 0;
  logic [31:0] rx_sr    = 32'h0;
  logic [31:0] last_rx_l = SENTINEL, last_rx_r = SENTINEL;
  int          sck_rise = 0, bck_rise = 0, lck_rise = 0;
  int          s0, b0, l0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected DIN: slot (pos mod 128)/4; slot 1 carries bit 15 ... slot 16 bit 0.
  function automatic logic exp_din(input int p, input logic [15:0] w);
    int k;
    k = (p % 128) / 4 - 1;
    if (k >= 0 && k < 16) return w[15 - k];
    return 1'b0;
  endfunction

  // What a receiver should collect over one 32-slot half-frame.
  function automatic logic [31:0] half_pattern(input logic [15:0] w);
    return {1'b0, w, 15'b0};
  endfunction

  // One CLK: advance the model at the edge, then check on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      pos  = 0;
      word = 16'h0000;
    end else if (pos == 255) begin
      pos  = 0;
      word = smp;
    end else begin
      pos++;
    end
    @(negedge clk);

    check("sck", 32'(sck), SCK_ON ? 32'(pos % 2) : 32'd0);
    check("bck", 32'(bck), 32'((pos % 4) / 2));
    check("lck", 32'(lck), 32'(pos / 128));
    check("din", 32'(din), 32'(exp_din(pos, word)));

    if (sck && !prev_sck) sck_rise++;
    if (lck != prev_lck) begin
      check("lck_edge_on_bck_fall", 32'({prev_bck, bck}), 32'b10);
      bit_cnt = 0;
      if (lck) lck_rise++;
    end
    if (bck && !prev_bck) begin
      bck_rise++;
      rx_sr = {rx_sr[30:0], din};
      bit_cnt++;
      if (bit_cnt == 32) begin
        if (lck) begin
          last_rx_r = rx_sr;
          check("rx_right", rx_sr, half_pattern(word));
        end else begin
          last_rx_l = rx_sr;
          check("rx_left", rx_sr, half_pattern(word));
        end
        bit_cnt = 0;
      end
    end
    if (rst) bit_cnt = 0;
    prev_sck = sck;
    prev_bck = bck;
    prev_lck = lck;
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 300 && pos != p; i++) tick();
  endtask

  initial begin
    // Reset held for three cycles.
    rst = 1'b1;
    smp = 16'h5A5A;
    repeat (3) tick();
    check("rst_outputs", 32'({sck, bck, lck, din}), 32'd0);

    // Release: SCK after 1 CLK, BCK after 2, LCK after 128.
    rst = 1'b0;
    tick();
    check("sck_after_1", 32'(sck), 32'(SCK_ON));
    check("bck_low_after_1", 32'(bck), 32'd0);
    tick();
    check("bck_after_2", 32'(bck), 32'd1);
    run_to(127);
    check("lck_low_at_127", 32'(lck), 32'd0);
    tick();
    check("lck_after_128", 32'(lck), 32'd1);

    // Clock ratios over 1024 CLK with random sample changes.
    s0 = sck_rise; b0 = bck_rise; l0 = lck_rise;
    repeat (1024) begin
      if ($urandom_range(0, 63) == 0) smp = 16'($urandom);
      tick();
    end
    check("sck_periods", 32'(sck_rise - s0), SCK_ON ? 32'd512 : 32'd0);
    check("bck_periods", 32'(bck_rise - b0), 32'd256);
    check("lck_periods", 32'(lck_rise - l0), 32'd4);

    // Data format with 16'h8001 on both channels.
    smp = 16'h8001;
    run_to(255);
    last_rx_l = SENTINEL;
    last_rx_r = SENTINEL;
    repeat (256) tick();
    check("fmt_left",  last_rx_l, 32'h4000_8000);
    check("fmt_right", last_rx_r, 32'h4000_8000);

    // Latch timing: change at c = 100 is held off until the next frame.
    smp = 16'h1234;
    tick();
    run_to(100);
    smp = 16'hFFFF;
    last_rx_r = SENTINEL;
    run_to(255);
    check("latch_right_old", last_rx_r, half_pattern(16'h1234));
    last_rx_l = SENTINEL;
    last_rx_r = SENTINEL;
    repeat (256) tick();
    check("latch_left_new",  last_rx_l, half_pattern(16'hFFFF));
    check("latch_right_new", last_rx_r, half_pattern(16'hFFFF));

    // Mid-frame reset at c = 40 while 16'h7FFF is in flight.
    smp = 16'h7FFF;
    tick();
    run_to(40);
    rst = 1'b1;
    tick();
    check("midrst_outputs", 32'({sck, bck, lck, din}), 32'd0);
    rst = 1'b0;
    last_rx_l = SENTINEL;
    last_rx_r = SENTINEL;
    repeat (255) tick();
    check("midrst_left_zero",  last_rx_l, 32'd0);
    check("midrst_right_zero", last_rx_r, 32'd0);
    last_rx_l = SENTINEL;
    last_rx_r = SENTINEL;
    repeat (256) tick();
    check("midrst_left_next",  last_rx_l, half_pattern(16'h7FFF));
    check("midrst_right_next", last_rx_r, half_pattern(16'h7FFF));

    // Random samples, changed at random points in each frame.
    repeat (6 * 256) begin
      if ($urandom_range(0, 99) == 0) smp = 16'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_i2s_master
